bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_add3.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 87 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the sequential binary-to-BCD converter.
// Holds FSM state encoding and the double-dabble adjust threshold.
package bcd_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  localparam nibble_t ADJ_THRESH = 4'd5;
  localparam nibble_t ADJ_ADD    = 4'd3;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// A legal digit (0..9) plus 3 is at most 12, so 4 bits never overflow.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one shift per clock (double dabble).
// Result is latched on bcd with a one-cycle done pulse after W shifts.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int W  = 8,
  parameter int ND = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  localparam int CW = cnt_width(W);

  logic [0:0]      state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [4*ND-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [4*ND-1:0] bcd_q, bcd_d;
  logic            done_q, done_d;
  logic [4*ND-1:0] adj;

  for (genvar i = 0; i < ND; i++) begin : g_adj
    bcd_add3 u_add3 (
      .din  (acc_q[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d    = bin;
          acc_d   = '0;
          cnt_d   = CW'(W);
          state_d = S_CONV;
        end
      end
      S_CONV: begin
        {acc_d, sr_d} = {adj, sr_q} << 1;
        cnt_d = cnt_q - CW'(1);
        // Last shift: publish the freshly shifted accumulator directly.
        if (cnt_q == CW'(1)) begin
          bcd_d   = acc_d;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == S_CONV);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (W=8, ND=3).
// Directed vector table plus multi-cycle corner sequences.
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int n_cmp = 0;
  int n_bad = 0;

  bin_to_bcd_seq #(.W(8), .ND(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // One start pulse; returns cycles to done (99 on timeout).
  task automatic conv(input logic [7:0] b, output int lat);
    @(negedge clk);
    start = 1'b1;
    bin   = b;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'hxx;
    check("busy_after_accept", int'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) lat = 99;
  endtask

  initial begin
    int lat;
    int ndone;
    logic [11:0] got;

    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd99,  12'h099};
    vecs[3] = '{8'd1,   12'h001};
    vecs[4] = '{8'd9,   12'h009};
    vecs[5] = '{8'd10,  12'h010};
    vecs[6] = '{8'd100, 12'h100};
    vecs[7] = '{8'd128, 12'h128};
    vecs[8] = '{8'd200, 12'h200};
    vecs[9] = '{8'd59,  12'h059};

    start = 1'b0;
    bin   = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_bcd", int'(bcd), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_hold_done", int'(done), 0);

    foreach (vecs[i]) begin
      conv(vecs[i].bin, lat);
      check($sformatf("latency[%0d]", vecs[i].bin), lat, 8);
      check($sformatf("bcd[%0d]", vecs[i].bin), int'(bcd), int'(vecs[i].exp));
      check("busy_in_done_cycle", int'(busy), 0);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("bcd_hold", int'(bcd), int'(vecs[i].exp));
    end

    // Start during conversion is ignored.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd123;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    bin   = 8'd7;
    @(negedge clk);
    start = 1'b0;
    check("bcd_hold_during_conv", int'(bcd), 12'h059);
    ndone = 0;
    got   = '0;
    repeat (20) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        got = bcd;
      end
    end
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_bcd", int'(got), 12'h123);

    // Asynchronous reset mid-conversion.
    @(negedge clk);
    start = 1'b1;
    bin   = 8'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_bcd", int'(bcd), 0);
    ndone = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("aborted_no_done", ndone, 0);
    conv(8'd45, lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_bcd", int'(bcd), 12'h045);

    // Start held high, sweep every input back to back.
    @(negedge clk);
    start = 1'b1;
    for (int v = 0; v < 256; v++) begin
      int c;
      bin = 8'(v);
      c = 0;
      do begin
        @(negedge clk);
        c++;
      end while (!done && c < 20);
      check($sformatf("sweep_period[%0d]", v), c, 9);
      check($sformatf("sweep_bcd[%0d]", v), int'(bcd), int'(ref_bcd(v)));
      if (bcd[11:8] > 4'd9 || bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9) begin
        check($sformatf("sweep_nibble_range[%0d]", v), int'(bcd), int'(ref_bcd(v)));
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("final_idle_busy", int'(busy), 0);
    check("final_bcd_hold", int'(bcd), 12'h255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
